// File: rtl/int_rst_ctrl.sv
// ---------------------------------------------------------------------------
// int_rst_ctrl
//   Multi-channel interrupt controller and reset sequencer for the pipelined
//   SCPU. It holds the CPU in reset for RST_HOLD clock edges after reset_n is
//   released. It collects interrupt requests from N_IRQ peripheral lines,
//   masks them and hands the highest-priority one (lowest index) to the CPU
//   over INT/int_id with an ack / end-of-interrupt handshake.
//
//   Optional build macro INT_LEVEL_EN:
//     undefined (default): pend bits are sticky and set on irq_in rising edges.
//                          They are cleared by PEND_CLR writes or by int_ack.
//     defined            : pend mirrors irq_in (registered) and nothing clears it.
//                          A source must drop its line before EOI.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   irq_in     in   [N_IRQ-1:0] interrupt sources, synchronous to clk
//   sel        in   device select from the address decoder
//   we         in   write enable, qualified by sel
//   addr       in   [1:0] word address: 0 PEND, 1 MASK, 2 PEND_CLR, 3 EOI/STAT
//   wdata      in   [31:0] write data
//   rdata      out  [31:0] read data, combinational from addr, 0 when sel=0
//   cpu_reset  out  active-high reset to the SCPU
//   INT        out  interrupt request to the SCPU
//   int_ack    in   one-cycle pulse: the CPU has taken the interrupt
//   int_id     out  [ID_W-1:0] channel being requested or serviced
// ---------------------------------------------------------------------------
module int_rst_ctrl #(
  parameter int N_IRQ    = 4,
  parameter int RST_HOLD = 3,
  parameter int ID_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             cpu_reset,
  output logic             INT,
  input  logic             int_ack,
  output logic [ID_W-1:0]  int_id
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2,
    ST_SERV = 2'd3
  } state_e;

  localparam int                CNT_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RST_HOLD - 1);

  // Lowest set index wins (channel 0 has the highest priority).
  function automatic logic [ID_W-1:0] first_set(input logic [N_IRQ-1:0] v);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  // One-hot channel mask for a channel number.
  function automatic logic [N_IRQ-1:0] id_to_mask(input logic [ID_W-1:0] id);
    logic [N_IRQ-1:0] m;
    for (int i = 0; i < N_IRQ; i++) m[i] = (id == ID_W'(i));
    return m;
  endfunction

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             int_q,       int_d;
  logic [ID_W-1:0]  int_id_q,    int_id_d;
  logic [N_IRQ-1:0] pend_q,      pend_d;
  logic [N_IRQ-1:0] mask_q,      mask_d;
  logic [N_IRQ-1:0] irq_d_q;

  logic             bus_wr_s, mask_wr_s, clr_wr_s, eoi_wr_s;
  logic             ack_take_s;
  logic [N_IRQ-1:0] req_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  // Bus writes are ignored while the CPU is still held in reset.
  assign bus_wr_s  = sel & we & (state_q != ST_HOLD);
  assign mask_wr_s = bus_wr_s & (addr == 2'd1);
  assign clr_wr_s  = bus_wr_s & (addr == 2'd2);
  assign eoi_wr_s  = bus_wr_s & (addr == 2'd3);
  assign req_s     = pend_q & mask_q;

  // Controller next state: reset hold, request, service handshake.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cpu_reset_d = cpu_reset_q;
    int_d       = int_q;
    int_id_d    = int_id_q;
    ack_take_s  = 1'b0;
    case (state_q)
      ST_HOLD: begin
        int_d = 1'b0;
        if (hold_cnt_q == HOLD_LAST) begin
          cpu_reset_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (req_s != {N_IRQ{1'b0}}) begin
          state_d  = ST_REQ;
          int_d    = 1'b1;
          int_id_d = first_set(req_s);
        end else begin
          int_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          // int_id_q is the channel the CPU saw; keep it for the service phase.
          ack_take_s = 1'b1;
          int_d      = 1'b0;
          state_d    = ST_SERV;
        end else if (req_s == {N_IRQ{1'b0}}) begin
          int_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          int_d    = 1'b1;
          int_id_d = first_set(req_s);
        end
      end
      ST_SERV: begin
        int_d = 1'b0;
        if (eoi_wr_s) state_d = ST_IDLE;
        else          state_d = ST_SERV;
      end
      default: begin
        state_d     = ST_HOLD;
        hold_cnt_d  = {CNT_W{1'b0}};
        cpu_reset_d = 1'b1;
        int_d       = 1'b0;
      end
    endcase
  end

  // Pending and mask register next state.
  always_comb begin
`ifdef INT_LEVEL_EN
    pend_d = irq_in & ~{N_IRQ{cpu_reset_q}};
`else
    // A new edge wins over both a bus clear and an ack clear of the same bit.
    if (state_q != ST_HOLD) begin
      pend_d = (pend_q
                & ~(clr_wr_s   ? wdata[N_IRQ-1:0]     : {N_IRQ{1'b0}})
                & ~(ack_take_s ? id_to_mask(int_id_q) : {N_IRQ{1'b0}}))
               | (irq_in & ~irq_d_q);
    end else begin
      pend_d = pend_q;
    end
`endif
    if (mask_wr_s) mask_d = wdata[N_IRQ-1:0];
    else           mask_d = mask_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= {CNT_W{1'b0}};
      cpu_reset_q <= 1'b1;
      int_q       <= 1'b0;
      int_id_q    <= {ID_W{1'b0}};
      pend_q      <= {N_IRQ{1'b0}};
      mask_q      <= {N_IRQ{1'b0}};
      irq_d_q     <= {N_IRQ{1'b0}};
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      int_q       <= int_d;
      int_id_q    <= int_id_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      irq_d_q     <= irq_in;
    end
  end

  // Register read mux.
  always_comb begin
    rdata_s = 32'd0;
    if (sel) begin
      case (addr)
        2'd0:    rdata_s = 32'(pend_q);
        2'd1:    rdata_s = 32'(mask_q);
        2'd2:    rdata_s = 32'd0;
        2'd3:    rdata_s = (32'(state_q) << 4'd8) | 32'(int_id_q);
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

`ifdef INT_LEVEL_EN
  assign unused_s = ^{wdata, irq_d_q, ack_take_s, clr_wr_s};
`else
  assign unused_s = ^wdata[31:N_IRQ];
`endif

  assign rdata     = rdata_s;
  assign cpu_reset = cpu_reset_q;
  assign INT       = int_q;
  assign int_id    = int_id_q;

endmodule

// File: tb/tb_int_rst_ctrl.sv
module tb_int_rst_ctrl;
  localparam int N_IRQ    = 4;
  localparam int RST_HOLD = 3;
  localparam int ID_W     = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N_IRQ-1:0] irq_in;
  logic             sel, we, int_ack;
  logic [1:0]       addr;
  logic [31:0]      wdata, rdata;
  logic             cpu_reset, INT;
  logic [ID_W-1:0]  int_id;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: edges since reset release, phase number 0..3 as reported
  // in STAT, pending/mask sets, and the previous irq sample.
  int         m_edges;
  int         m_ph;
  logic       m_int;
  int         m_id;
  logic [3:0] m_pend, m_mask, m_irqd;

  always #5 clk = ~clk;

  int_rst_ctrl #(.N_IRQ(N_IRQ), .RST_HOLD(RST_HOLD), .ID_W(ID_W)) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .cpu_reset(cpu_reset),
    .INT(INT), .int_ack(int_ack), .int_id(int_id)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_edges = 0; m_ph = 0; m_int = 1'b0; m_id = 0;
    m_pend = 4'h0; m_mask = 4'h0; m_irqd = 4'h0;
  endtask

  function automatic logic [31:0] model_rdata();
    if (!sel) return 32'd0;
    case (addr)
      2'd0:    return {28'd0, m_pend};
      2'd1:    return {28'd0, m_mask};
      2'd3:    return (m_ph * 256) + m_id;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    logic [3:0] req, nxt_pend, clr;
    logic       wr;
    req = m_pend & m_mask;
    wr  = sel && we;
    if (m_edges < RST_HOLD) begin
      m_edges++;
      m_int = 1'b0;
      if (m_edges == RST_HOLD) m_ph = 1;
    end else begin
      clr = (wr && addr == 2'd2) ? wdata[3:0] : 4'h0;
      case (m_ph)
        1: if (req != 4'h0) begin m_ph = 2; m_int = 1'b1; m_id = lowest(req); end
           else m_int = 1'b0;
        2: if (int_ack) begin clr[m_id] = 1'b1; m_ph = 3; m_int = 1'b0; end
           else if (req == 4'h0) begin m_ph = 1; m_int = 1'b0; end
           else begin m_int = 1'b1; m_id = lowest(req); end
        default: begin m_int = 1'b0; if (wr && addr == 2'd3) m_ph = 1; end
      endcase
      nxt_pend = (m_pend & ~clr) | (irq_in & ~m_irqd);
      if (wr && addr == 2'd1) m_mask = wdata[3:0];
      m_pend = nxt_pend;
    end
    m_irqd = irq_in;
  endtask

  task automatic set_in(input logic [3:0] irq, input logic s, input logic w,
                        input logic [1:0] a, input logic [31:0] d, input logic ack);
    irq_in = irq; sel = s; we = w; addr = a; wdata = d; int_ack = ack;
  endtask

  // One clock: check the read port, step the model, check registered outputs.
  task automatic cycle(input string tag);
    #1;
    chk_eq({tag, "/rdata"}, rdata, model_rdata());
    model_step();
    @(posedge clk);
    #1;
    chk_eq({tag, "/cpu_reset"}, 32'(cpu_reset), 32'(m_edges < RST_HOLD));
    chk_eq({tag, "/INT"}, 32'(INT), 32'(m_int));
    chk_eq({tag, "/int_id"}, 32'(int_id), 32'(m_id));
  endtask

  task automatic idle(input string tag);
    set_in(4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    cycle(tag);
  endtask

  task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
    set_in(4'h0, 1'b1, 1'b0, a, 32'd0, 1'b0);
    #1;
    chk_eq(tag, rdata, exp);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before the next edge.
  task automatic do_reset(input string tag);
    sel = 1'b1; we = 1'b0; addr = 2'd0;
    reset_n = 1'b0;
    #1;
    chk_eq({tag, "/rst_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk_eq({tag, "/rst_INT"}, 32'(INT), 32'd0);
    chk_eq({tag, "/rst_int_id"}, 32'(int_id), 32'd0);
    chk_eq({tag, "/rst_PEND"}, rdata, 32'd0);
    addr = 2'd1;
    #1;
    chk_eq({tag, "/rst_MASK"}, rdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r_irq;
    reset_n = 1'b0;
    set_in(4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_eq("t1_reset_cpu_reset", 32'(cpu_reset), 32'd1);
    chk_eq("t1_reset_INT", 32'(INT), 32'd0);
    reset_n = 1'b1;

    // 1: hold for exactly RST_HOLD edges; irq edges in HOLD are ignored
    set_in(4'h1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    cycle("t1_e1"); chk_eq("t1_e1_lit", 32'(cpu_reset), 32'd1);
    cycle("t1_e2"); chk_eq("t1_e2_lit", 32'(cpu_reset), 32'd1);
    cycle("t1_e3"); chk_eq("t1_e3_lit", 32'(cpu_reset), 32'd0);
    chk_eq("t1_INT", 32'(INT), 32'd0);
    peek("t1_pend_ignored", 2'd0, 32'd0);
    idle("t1_idle");

    // 2: single irq on channel 2
    set_in(4'h0, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0); cycle("t2_mask");
    peek("t2_mask_rd", 2'd1, 32'h0000_000F);
    set_in(4'h4, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0); cycle("t2_irq");
    idle("t2_req");
    chk_eq("t2_INT_lit", 32'(INT), 32'd1);
    chk_eq("t2_id_lit", 32'(int_id), 32'd2);
    set_in(4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1); cycle("t2_ack");
    chk_eq("t2_ack_INT_lit", 32'(INT), 32'd0);
    peek("t2_pend_lit", 2'd0, 32'd0);
    cycle("t2_rd");
    set_in(4'h0, 1'b1, 1'b1, 2'd3, 32'd0, 1'b0); cycle("t2_eoi");
    peek("t2_stat_lit", 2'd3, 32'h0000_0102);
    cycle("t2_stat");

    // 3: priority, then re-assertion of the lower-priority channel after EOI
    set_in(4'hA, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0); cycle("t3_irq");
    idle("t3_req");
    chk_eq("t3_id1_lit", 32'(int_id), 32'd1);
    set_in(4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1); cycle("t3_ack");
    set_in(4'h0, 1'b1, 1'b1, 2'd3, 32'd0, 1'b0); cycle("t3_eoi");
    chk_eq("t3_eoi_INT_lit", 32'(INT), 32'd0);
    idle("t3_req3");
    chk_eq("t3_INT3_lit", 32'(INT), 32'd1);
    chk_eq("t3_id3_lit", 32'(int_id), 32'd3);
    set_in(4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1); cycle("t3_ack3");
    set_in(4'h0, 1'b1, 1'b1, 2'd3, 32'd0, 1'b0); cycle("t3_eoi3");

    // 4: masked pending, then unmask
    set_in(4'h0, 1'b1, 1'b1, 2'd1, 32'd0, 1'b0); cycle("t4_mask0");
    set_in(4'h1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0); cycle("t4_irq");
    idle("t4_wait");
    chk_eq("t4_INT0_lit", 32'(INT), 32'd0);
    peek("t4_pend_lit", 2'd0, 32'd1);
    cycle("t4_rd");
    set_in(4'h0, 1'b1, 1'b1, 2'd1, 32'd1, 1'b0); cycle("t4_mask1");
    chk_eq("t4_INT_e1_lit", 32'(INT), 32'd0);
    idle("t4_e2");
    chk_eq("t4_INT_e2_lit", 32'(INT), 32'd1);
    set_in(4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1); cycle("t4_ack");
    set_in(4'h0, 1'b1, 1'b1, 2'd3, 32'd0, 1'b0); cycle("t4_eoi");

    // 5: new edge and PEND_CLR on the same bit in the same cycle
    set_in(4'h0, 1'b1, 1'b1, 2'd1, 32'd0, 1'b0); cycle("t5_mask0");
    set_in(4'h1, 1'b1, 1'b1, 2'd2, 32'd1, 1'b0); cycle("t5_coll");
    peek("t5_pend_lit", 2'd0, 32'd1);
    cycle("t5_rd");

    // 6: reset while servicing, then the hold sequence again
    set_in(4'h0, 1'b1, 1'b1, 2'd1, 32'hF, 1'b0); cycle("t6_mask");
    idle("t6_req");
    set_in(4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1); cycle("t6_ack");
    peek("t6_serv_lit", 2'd3, 32'h0000_0300);
    do_reset("t6");
    idle("t6_h1"); chk_eq("t6_h1_lit", 32'(cpu_reset), 32'd1);
    idle("t6_h2"); chk_eq("t6_h2_lit", 32'(cpu_reset), 32'd1);
    idle("t6_h3"); chk_eq("t6_h3_lit", 32'(cpu_reset), 32'd0);

    // Randomized traffic against the model
    r_irq = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd");
      end else begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 3) == 0) r_irq[b] = ~r_irq[b];
        set_in(r_irq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 2) == 0));
        cycle("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
